ub_read_streamer: RTL

- Read-side initiator for the unified buffer read port (port A). Accepts a (start address, length) command from the controller and splits it into bursts of at most MAX_BURST words.
- Issues each burst on the UB read handshake, captures the returned words in a local FIFO, and presents them to the systolic array loader as a valid/ready stream with a last flag.
- Provides credit-based flow control, which the UB read port lacks because it has no backpressure, plus a watchdog on missing return data.

---
 rtl/tpu_ub_pkg.sv | 22 ++
 rtl/ub_stream_fifo.sv | 75 +++++++
 rtl/ub_read_streamer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_ub_pkg.sv
// tpu_ub_pkg
// Shared definitions for the unified-buffer read path.
//   ub_rd_state_t : read streamer FSM states
//   UB_*_WIDTH    : default UB word and address widths
//   min_len       : smaller of two word counts, used to size bursts
package tpu_ub_pkg;

    localparam int UB_DATA_WIDTH = 256;
    localparam int UB_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DRAIN     = 2'd3
    } ub_rd_state_t;

    function automatic int unsigned min_len(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ub_stream_fifo.sv
// ub_stream_fifo
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever
// the FIFO is not empty, and pop simply advances past it.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   flush           synchronous empty, same effect as rst on pointers/count
//   push, wr_data   write an entry (ignored when full)
//   pop             consume the head entry (ignored when empty)
//   rd_data         head entry
//   empty, full     status
//   count           current occupancy, 0..DEPTH
module ub_stream_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // The writer is credit-limited, so a push into a full FIFO is a design bug.
    assert property (@(posedge clk) disable iff (rst || flush) !(push && full));

endmodule

// File: rtl/ub_read_streamer.sv
// ub_read_streamer
// Read-side initiator for UB port A. A (cmd_addr, cmd_len) command is split
// into bursts of at most MAX_BURST words; returned words are buffered in a
// show-ahead FIFO and streamed out with a last flag on the final word.
// The UB port has no backpressure, so a burst is only issued when the FIFO
// has room for every word of it (credits).
//
// Handshakes: cmd and out use valid/ready; a transfer happens on a rising
// edge where both valid and ready are high. valid never depends on ready.
// The UB side is request/response: ub_rd_en pulses one cycle with
// ub_addr/ub_count, then ub_valid qualifies one returned word per cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/ready/addr/len      command input
//   ub_rd_en/addr/count           burst request to UB
//   ub_data/ub_valid              UB return data
//   out_valid/ready/data/last     output stream
//   busy, done                    status; done pulses once per command
//   err_timeout, err_unexpected   sticky error flags
//   dbg_state                     current FSM state (ub_rd_state_t encoding)
module ub_read_streamer
    import tpu_ub_pkg::*;
#(
    parameter int DATA_WIDTH     = UB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = UB_ADDR_WIDTH,
    parameter int MAX_BURST      = 16,
    parameter int FIFO_DEPTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  ub_rd_en,
    output logic [ADDR_WIDTH-1:0] ub_addr,
    output logic [ADDR_WIDTH-1:0] ub_count,
    input  logic [DATA_WIDTH-1:0] ub_data,
    input  logic                  ub_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  err_unexpected,
    output logic [1:0]            dbg_state
);

    localparam int LW    = ADDR_WIDTH + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WW    = (LW > CW) ? LW : CW;
    // After reset, words of an abandoned burst may still arrive; they are
    // dropped silently for this many cycles instead of raising err_unexpected.
    localparam int QUIET = MAX_BURST + 4;
    localparam int QW    = $clog2(QUIET + 1);

    ub_rd_state_t state, state_n;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LW-1:0]         remaining;
    logic [LW-1:0]         burst_q;
    logic [LW-1:0]         received;
    logic [TW-1:0]         wd_cnt;
    logic [QW-1:0]         quiet_cnt;
    logic                  done_q;
    logic                  err_timeout_q;
    logic                  err_unexp_q;

    logic [LW-1:0]         burst;
    logic [LW-1:0]         outstanding;
    logic [CW-1:0]         credits;
    logic                  can_issue;
    logic                  cmd_fire;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  word_done;
    logic                  final_burst;
    logic                  wd_expire;
    logic                  unexp;

    logic [DATA_WIDTH:0]   f_rd;
    logic                  f_empty;
    logic                  f_full;
    logic [CW-1:0]         f_count;

    // ---------------- credit / burst sizing ----------------
    assign burst       = LW'(min_len(32'(remaining), MAX_BURST));
    assign outstanding = (state == WAIT_DATA) ? (burst_q - received) : '0;
    assign credits     = CW'(FIFO_DEPTH) - f_count - CW'(outstanding);
    assign can_issue   = WW'(credits) >= WW'(burst);

    // ---------------- handshakes and events ----------------
    assign cmd_ready   = (state == IDLE) && !rst;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign out_valid   = !f_empty && !rst;
    assign pop         = out_valid && out_ready;
    assign push        = (state == WAIT_DATA) && ub_valid && !rst;
    assign word_done   = push && ((received + LW'(1)) == burst_q);
    assign final_burst = (remaining == burst_q);
    assign wd_expire   = (state == WAIT_DATA) && !ub_valid && !rst &&
                         (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign unexp       = ub_valid && (state != WAIT_DATA) && (quiet_cnt == '0) && !rst;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_fire && (cmd_len != '0)) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (can_issue) begin
                    issue   = 1'b1;
                    state_n = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (wd_expire) begin
                    state_n = IDLE;
                end else if (word_done) begin
                    state_n = final_burst ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (pop && f_rd[DATA_WIDTH]) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            remaining     <= '0;
            burst_q       <= '0;
            received      <= '0;
            wd_cnt        <= '0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_unexp_q   <= 1'b0;
            quiet_cnt     <= QW'(QUIET);
        end else begin
            state  <= state_n;
            done_q <= (cmd_fire && (cmd_len == '0)) ||
                      ((state == DRAIN) && pop && f_rd[DATA_WIDTH]);
            if (quiet_cnt != '0) begin
                quiet_cnt <= quiet_cnt - QW'(1);
            end
            if (cmd_fire) begin
                addr_q    <= cmd_addr;
                remaining <= cmd_len;
            end
            if (issue) begin
                burst_q  <= burst;
                received <= '0;
                wd_cnt   <= '0;
            end
            if (push) begin
                received <= received + LW'(1);
                wd_cnt   <= '0;
                if (word_done) begin
                    remaining <= remaining - burst_q;
                    // Address wraps modulo the UB depth.
                    addr_q    <= addr_q + burst_q[ADDR_WIDTH-1:0];
                end
            end else if (state == WAIT_DATA) begin
                wd_cnt <= wd_cnt + TW'(1);
            end
            if (wd_expire) begin
                err_timeout_q <= 1'b1;
            end
            if (unexp) begin
                err_unexp_q <= 1'b1;
            end
        end
    end

    // ---------------- return FIFO ----------------
    ub_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (wd_expire),
        .push    (push),
        .wr_data ({word_done && final_burst, ub_data}),
        .pop     (pop),
        .rd_data (f_rd),
        .empty   (f_empty),
        .full    (f_full),
        .count   (f_count)
    );

    // ---------------- outputs (forced to 0 while rst is high) ----------------
    assign ub_rd_en       = issue && !rst;
    assign ub_addr        = ub_rd_en ? addr_q : '0;
    assign ub_count       = ub_rd_en ? burst[ADDR_WIDTH-1:0] : '0;
    assign out_data       = rst ? '0 : f_rd[DATA_WIDTH-1:0];
    assign out_last       = out_valid && f_rd[DATA_WIDTH];
    assign busy           = (state != IDLE) && !rst;
    assign done           = done_q && !rst;
    assign err_timeout    = err_timeout_q && !rst;
    assign err_unexpected = err_unexp_q && !rst;
    assign dbg_state      = rst ? 2'b00 : state;

endmodule
